control_unit_sequencer: RTL and testbench
=========================================

# control_unit_sequencer

Hardwired control unit that drives every control input of the arithmetic-logic-unit datapath system. It fetches 16-bit instructions from the byte-wide memory in two cycles, decodes them, and issues per-cycle control words to the register file (RF), ALU, address register file (ARF), instruction register (IR), memory and the three muxes. Instructions take 3 or 4 cycles. The block sits directly upstream of the datapath and consumes only `IROut` and the ALU flags from it.

## Interface
- No parameters.
- `Clock  in  1  system clock, rising edge`
- `Reset  in  1  asynchronous, active-high`
- `IROut  in  16  IR contents from datapath`
- `Flags  in  4  ALU FlagOut; bit3 = Z`
- `Step  in  1  single-step advance (only with CU_STEP_EN)`
- `RF_OutASel, RF_OutBSel, RF_FunSel  out  3 each  RF controls`
- `RF_RegSel, RF_ScrSel  out  4 each  RF enables, active-high; RF_RegSel 1000=R1 … 0001=R4`
- `ALU_FunSel  out  5  ALU function`
- `ALU_WF  out  1  flag write enable`
- `ARF_OutCSel, ARF_OutDSel  out  2 each  ARF outputs; OutD 00=PC, 10=AR`
- `ARF_FunSel, ARF_RegSel  out  3 each  ARF controls; RegSel 100=PC, 010=AR, 001=SP`
- `IR_LH, IR_Write, Mem_WR, Mem_CS  out  1 each  IR and memory controls; Mem_CS active-low`
- `MuxASel, MuxBSel  out  2 each`
- `MuxCSel  out  1`
- `Tstate  out  3  current timing state`
- `Halted  out  1  registered halt indicator`

## Operation
- **Idle word:**
  - All RF/ARF/scratch enables = 0.
  - IR_Write = 0, ALU_WF = 0, Mem_CS = 1, Mem_WR = 0.
  - Every select = 0, ARF_OutCSel = 00.
- **Function codes:**
  - RF load = 010; ARF load = 010; ARF increment = 001.
  - ALU pass-A = 10000.
- **States:** T0, T1, T2, T3, HALT, plus WAIT (macro only).
- **T0 (fetch low byte):**
  - Drive ARF_OutDSel = 00, Mem_CS = 0, Mem_WR = 0, IR_Write = 1, IR_LH = 0.
  - Drive ARF_RegSel = 100, ARF_FunSel = 001 (PC++).
  - Go to T1.
- **T1 (fetch high byte):** same as T0 but IR_LH = 1. Go to T2.
- **T2 (decode/execute).** Class is IR[15:14]:
  - **00 ALU:**
    - ALU_FunSel = IR[13:9], RF_OutASel = IR[5:3], RF_OutBSel = IR[2:0], ALU_WF = 1.
    - MuxASel = 00, RF_FunSel = 010, RF_RegSel = one-hot(IR[7:6]).
    - If IR[8] = 1, the instruction is illegal: drive the idle word.
    - Go to T0.
  - **01 LDI:** MuxASel = 11, RF_FunSel = 010, RF_RegSel = one-hot(IR[9:8]). Go to T0.
  - **10 LD/ST:** MuxBSel = 11, ARF_RegSel = 010, ARF_FunSel = 010 (AR ← IR[7:0]). Go to T3.
  - **11 BR:**
    - IR[12] = 1 is HLT: drive the idle word, set Halted, go to HALT.
    - Otherwise the branch is taken if IR[13] = 0, or if IR[13] = 1 and Flags[3] = 1.
    - Taken: MuxBSel = 11, ARF_RegSel = 100, ARF_FunSel = 010 (PC ← {8'h00, IR[7:0]}).
    - Not taken: idle word.
    - Go to T0.
- **T3 (memory access).** Common: ARF_OutDSel = 10, Mem_CS = 0.
  - IR[13] = 0 (LD): Mem_WR = 0, MuxASel = 10, RF_FunSel = 010, RF_RegSel = one-hot(IR[9:8]).
  - IR[13] = 1 (ST): Mem_WR = 1, RF_OutASel = {1'b0, IR[9:8]}, ALU_FunSel = 10000, MuxCSel = 0.
  - Go to T0.
- **HALT:** idle word every cycle. Only Reset exits.
- **Outputs:** combinational decode of state and `IROut`. `Tstate` encoding: T0 = 0, T1 = 1, T2 = 2, T3 = 3, HALT = 7, WAIT = 6.

## Timing
- **Reset asserted:** all outputs forced to the idle word combinationally, in the same cycle. State ← T0, Halted ← 0, Tstate = 0.
- **First fetch:** T0 control word appears in the first cycle after Reset deasserts.
- **Instruction latency:** ALU/LDI/BR/HLT take 3 cycles; LD/ST take 4.
- **Decode timing:** IR is written at the end of T1. T2 decode uses the registered `IROut`.
- **Datapath assumptions:** memory read is combinational and memory write is synchronous. ALUOut is combinational from RF outputs, so ALU results load into the RF at the T2 edge.
- **Branch condition:** Flags are sampled during T2. A flag written by the previous instruction's T2 edge is valid.
- **Halted:** rises on the edge leaving a HLT T2 and stays high until Reset.
- **Reset mid-instruction (any state):** operation aborts immediately. No partial write occurs after Reset rises.

## Configuration
- **`CU_STEP_EN` defined:**
  - The `Step` port exists.
  - From T0, the sequencer enters WAIT (idle word, no fetch) and stays there until Step = 1 is sampled; it then performs T0 on the next cycle.
  - One instruction executes per Step pulse. A held-high Step runs continuously.
  - Reset still exits to T0 with WAIT logic active.
- **`CU_STEP_EN` undefined:** no `Step` port, WAIT is unreachable, instructions execute back-to-back.

## Test plan
- **Reset and LDI:** Reset, then release with mem[0] = 0x05, mem[1] = 0x41 (LDI R2, 0x05).
  - Expect: T0 with IR_LH = 0 and PC++; T1 with IR_LH = 1; T2 with MuxASel = 11, RF_RegSel = 0100, RF_FunSel = 010; back to T0 at cycle 4.
- **ALU op:** IROut = 0x0851.
  - Expect at T2: ALU_FunSel = 00100, RF_OutASel = 010, RF_OutBSel = 001, ALU_WF = 1, RF_RegSel = 0100.
- **Load:** IROut = 0x8020.
  - Expect at T2: MuxBSel = 11, ARF_RegSel = 010, ARF_FunSel = 010.
  - Expect at T3: ARF_OutDSel = 10, Mem_CS = 0, Mem_WR = 0, MuxASel = 10, RF_RegSel = 1000.
- **Conditional branch:** IROut = 0xE040.
  - Flags = 0000: ARF_RegSel = 000 at T2.
  - Flags = 1000: MuxBSel = 11, ARF_RegSel = 100, ARF_FunSel = 010.
- **Halt:** IROut = 0xF000.
  - Expect Halted = 1 and Tstate = 7 from the next cycle, idle word held for 20 cycles. Reset then clears Halted and returns Tstate to 0.
- **Reset mid-store:** IROut = 0xA130, assert Reset during T3.
  - Expect Mem_CS = 1 in the same cycle, and T0 on the first cycle after release.

Source files
------------

// File: rtl/control_unit_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the ALU datapath system.
// Optional single-step mode is enabled by defining CU_STEP_EN.
`timescale 1ns/1ps
module control_unit_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
`ifdef CU_STEP_EN
  input  logic        Step,
`endif
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  Tstate,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_WAIT = 3'd6,
    S_HALT = 3'd7
  } state_t;

`ifdef CU_STEP_EN
  localparam state_t S_NEXT = S_WAIT;
`else
  localparam state_t S_NEXT = S_T0;
`endif

  state_t state_q, state_d;
  logic   halted_q;

  logic unused_flags;
  assign unused_flags = ^Flags[2:0];

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    onehot = 4'b1000 >> sel;
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  // Everything below Reset gating is the idle word, so reset suppresses any write.
  always_comb begin
    state_d     = state_q;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 3'b000;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_T0, S_T1: begin
          Mem_CS     = 1'b0;
          IR_Write   = 1'b1;
          IR_LH      = (state_q == S_T1);
          ARF_RegSel = 3'b100;
          ARF_FunSel = 3'b001;
          state_d    = (state_q == S_T0) ? S_T1 : S_T2;
        end
        S_T2: begin
          state_d = S_NEXT;
          case (IROut[15:14])
            2'b00: begin
              if (!IROut[8]) begin
                ALU_FunSel = IROut[13:9];
                RF_OutASel = IROut[5:3];
                RF_OutBSel = IROut[2:0];
                ALU_WF     = 1'b1;
                RF_FunSel  = 3'b010;
                RF_RegSel  = onehot(IROut[7:6]);
              end
            end
            2'b01: begin
              MuxASel   = 2'b11;
              RF_FunSel = 3'b010;
              RF_RegSel = onehot(IROut[9:8]);
            end
            2'b10: begin
              MuxBSel    = 2'b11;
              ARF_RegSel = 3'b010;
              ARF_FunSel = 3'b010;
              state_d    = S_T3;
            end
            default: begin
              if (IROut[12]) begin
                state_d = S_HALT;
              end else if (!IROut[13] || Flags[3]) begin
                MuxBSel    = 2'b11;
                ARF_RegSel = 3'b100;
                ARF_FunSel = 3'b010;
              end
            end
          endcase
        end
        S_T3: begin
          ARF_OutDSel = 2'b10;
          Mem_CS      = 1'b0;
          if (!IROut[13]) begin
            MuxASel   = 2'b10;
            RF_FunSel = 3'b010;
            RF_RegSel = onehot(IROut[9:8]);
          end else begin
            Mem_WR     = 1'b1;
            RF_OutASel = {1'b0, IROut[9:8]};
            ALU_FunSel = 5'b10000;
          end
          state_d = S_NEXT;
        end
        S_HALT: state_d = S_HALT;
`ifdef CU_STEP_EN
        S_WAIT: state_d = Step ? S_T0 : S_WAIT;
`endif
        default: state_d = S_T0;
      endcase
    end
  end

  assign Tstate = state_q;
  assign Halted = halted_q;

endmodule

// File: tb/tb_control_unit_sequencer.sv
// Directed bench for control_unit_sequencer: drives IROut/Flags directly and
// checks control words against hand-derived values.
`timescale 1ns/1ps
module tb_control_unit_sequencer;
  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic        Step;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  Tstate;
  logic        Halted;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [41:0] IDLE = 42'd32;
  logic [41:0] cw;
  assign cw = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR,
               Mem_CS, MuxASel, MuxBSel, MuxCSel};

  control_unit_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
`ifdef CU_STEP_EN
    .Step(Step),
`endif
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .Tstate(Tstate), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic lh, input logic [2:0] ts);
    check({tag, "_tstate"}, 64'(Tstate), 64'(ts));
    check({tag, "_irw"}, 64'(IR_Write), 64'd1);
    check({tag, "_irlh"}, 64'(IR_LH), 64'(lh));
    check({tag, "_memcs"}, 64'(Mem_CS), 64'd0);
    check({tag, "_memwr"}, 64'(Mem_WR), 64'd0);
    check({tag, "_outd"}, 64'(ARF_OutDSel), 64'd0);
    check({tag, "_arfreg"}, 64'(ARF_RegSel), 64'b100);
    check({tag, "_arffun"}, 64'(ARF_FunSel), 64'b001);
  endtask

  initial begin
    Reset = 1'b1; IROut = 16'h0000; Flags = 4'h0; Step = 1'b1;
    tick(); tick();
    check("rst_tstate", 64'(Tstate), 64'd0);
    check("rst_halted", 64'(Halted), 64'd0);
    check("rst_idle", 64'(cw), 64'(IDLE));
    $display("reset: tstate=%0d halted=%0d", Tstate, Halted);

    // LDI R2, 0x05
    IROut = 16'h4105; Reset = 1'b0; #1;
    check_fetch("ldi_t0", 1'b0, 3'd0);
    tick(); check_fetch("ldi_t1", 1'b1, 3'd1);
    tick();
    check("ldi_t2_tstate", 64'(Tstate), 64'd2);
    check("ldi_t2_muxa", 64'(MuxASel), 64'b11);
    check("ldi_t2_rfreg", 64'(RF_RegSel), 64'b0100);
    check("ldi_t2_rffun", 64'(RF_FunSel), 64'b010);
    check("ldi_t2_irw", 64'(IR_Write), 64'd0);
    check("ldi_t2_memcs", 64'(Mem_CS), 64'd1);
    tick(); check("ldi_done_t0", 64'(Tstate), 64'd0);
    $display("ldi 4105: t2 muxa=%b rfreg=%b", 2'b11, 4'b0100);

    // ALU op
    IROut = 16'h0851;
    tick(); tick();
    check("alu_t2_fun", 64'(ALU_FunSel), 64'b00100);
    check("alu_t2_outa", 64'(RF_OutASel), 64'b010);
    check("alu_t2_outb", 64'(RF_OutBSel), 64'b001);
    check("alu_t2_wf", 64'(ALU_WF), 64'd1);
    check("alu_t2_rfreg", 64'(RF_RegSel), 64'b0100);
    check("alu_t2_rffun", 64'(RF_FunSel), 64'b010);
    check("alu_t2_muxa", 64'(MuxASel), 64'b00);
    tick(); check("alu_done_t0", 64'(Tstate), 64'd0);
    $display("alu 0851: fun=%b wf=%b", ALU_FunSel, ALU_WF);

    // Load
    IROut = 16'h8020;
    tick(); tick();
    check("ld_t2_muxb", 64'(MuxBSel), 64'b11);
    check("ld_t2_arfreg", 64'(ARF_RegSel), 64'b010);
    check("ld_t2_arffun", 64'(ARF_FunSel), 64'b010);
    tick();
    check("ld_t3_tstate", 64'(Tstate), 64'd3);
    check("ld_t3_outd", 64'(ARF_OutDSel), 64'b10);
    check("ld_t3_memcs", 64'(Mem_CS), 64'd0);
    check("ld_t3_memwr", 64'(Mem_WR), 64'd0);
    check("ld_t3_muxa", 64'(MuxASel), 64'b10);
    check("ld_t3_rfreg", 64'(RF_RegSel), 64'b1000);
    check("ld_t3_rffun", 64'(RF_FunSel), 64'b010);
    tick(); check("ld_done_t0", 64'(Tstate), 64'd0);
    $display("ld 8020: 4-cycle load checked");

    // Conditional branch, Z clear
    IROut = 16'hE040; Flags = 4'b0000;
    tick(); tick();
    check("bnt_t2_arfreg", 64'(ARF_RegSel), 64'b000);
    check("bnt_t2_idle", 64'(cw), 64'(IDLE));
    tick(); check("bnt_done_t0", 64'(Tstate), 64'd0);
    $display("br e040 z=0: not taken");

    // Conditional branch, Z set
    Flags = 4'b1000;
    tick(); tick();
    check("bt_t2_muxb", 64'(MuxBSel), 64'b11);
    check("bt_t2_arfreg", 64'(ARF_RegSel), 64'b100);
    check("bt_t2_arffun", 64'(ARF_FunSel), 64'b010);
    tick(); check("bt_done_t0", 64'(Tstate), 64'd0);
    $display("br e040 z=1: taken");

    // Illegal ALU (IR[8] set)
    IROut = 16'h0951; Flags = 4'b0000;
    tick(); tick();
    check("ill_t2_tstate", 64'(Tstate), 64'd2);
    check("ill_t2_idle", 64'(cw), 64'(IDLE));
    tick(); check("ill_done_t0", 64'(Tstate), 64'd0);
    $display("alu 0951 illegal: idle word");

    // Store with reset during T3
    IROut = 16'hA130;
    tick(); tick();
    check("st_t2_muxb", 64'(MuxBSel), 64'b11);
    check("st_t2_arfreg", 64'(ARF_RegSel), 64'b010);
    tick();
    check("st_t3_tstate", 64'(Tstate), 64'd3);
    check("st_t3_memwr", 64'(Mem_WR), 64'd1);
    check("st_t3_memcs", 64'(Mem_CS), 64'd0);
    check("st_t3_outd", 64'(ARF_OutDSel), 64'b10);
    check("st_t3_outa", 64'(RF_OutASel), 64'b001);
    check("st_t3_alufun", 64'(ALU_FunSel), 64'b10000);
    check("st_t3_muxc", 64'(MuxCSel), 64'd0);
    Reset = 1'b1; #1;
    check("st_rst_memcs", 64'(Mem_CS), 64'd1);
    check("st_rst_memwr", 64'(Mem_WR), 64'd0);
    check("st_rst_tstate", 64'(Tstate), 64'd0);
    check("st_rst_idle", 64'(cw), 64'(IDLE));
    tick();
    Reset = 1'b0; #1;
    check_fetch("st_rel_t0", 1'b0, 3'd0);
    $display("st a130: reset during T3 aborted");

    // Halt
    IROut = 16'hF000;
    tick(); tick();
    check("hlt_t2_idle", 64'(cw), 64'(IDLE));
    check("hlt_t2_halted", 64'(Halted), 64'd0);
    tick();
    check("hlt_halted", 64'(Halted), 64'd1);
    check("hlt_tstate", 64'(Tstate), 64'd7);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("hlt_hold%0d_idle", i), 64'(cw), 64'(IDLE));
      check($sformatf("hlt_hold%0d_tstate", i), 64'(Tstate), 64'd7);
      check($sformatf("hlt_hold%0d_halted", i), 64'(Halted), 64'd1);
    end
    Reset = 1'b1; #1;
    check("hlt_rst_halted", 64'(Halted), 64'd0);
    check("hlt_rst_tstate", 64'(Tstate), 64'd0);
    $display("hlt f000: halted held 20 cycles, reset cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
